// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Keeps a program counter, reads one word per
// cycle from a combinational main memory and buffers {pc, word} pairs in a
// small circular instruction queue. The consumer takes the queue head using
// a valid/ready handshake. A redirect flushes the queue and restarts fetch
// at a new target.
//
// Handshake (inst_*): the head entry is transferred on a rising edge where
// inst_valid && inst_ready are both 1. inst_valid never depends on
// inst_ready, and inst/inst_pc stay stable while inst_valid is 1 and the
// head is not taken. A redirect in the same cycle wins: nothing is
// transferred and the queue is emptied.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target flushes the queue,
//               sets sticky fetch_error and parks the FSM in ERROR until
//               reset.
//   undefined : redirect_pc[1:0] is ignored (treated as 0) and fetch_error
//               is tied low; ERROR is unreachable.
//
// Parameters:
//   STARTING_ADDR  PC value loaded on reset
//   DEPTH          queue entries, power of two, 2..16
//
// Ports:
//   clock           in   single clock, rising-edge
//   reset           in   asynchronous active-high reset
//   start           in   one-cycle pulse, IDLE -> FETCH
//   mem_address     out  32  word address to memory (always the PC)
//   mem_data_in     out  32  write data, constant 0
//   mem_read_write  out  1   constant 0 (read)
//   mem_data_out    in   32  combinational read data for mem_address
//   inst_valid      out  queue head holds an instruction
//   inst_ready      in   consumer accepts the head this cycle
//   inst            out  32  head instruction word
//   inst_pc         out  32  address the head was fetched from
//   redirect_valid  in   one-cycle request to restart at redirect_pc
//   redirect_pc     in   32  new fetch target
//   fetch_error     out  sticky misaligned-redirect flag
//   fsm_state       out  2   current FSM state (IDLE=0, FETCH=1, ERROR=2)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] STARTING_ADDR = 32'h0100_0000,
    parameter int          DEPTH         = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_error,
    output logic [1:0]  fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      pc;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [31:0] queue_inst [DEPTH];
    logic [31:0] queue_pc   [DEPTH];

    logic [31:0] redirect_target;
    logic        misaligned;
    logic        redirect_take;
    logic        push;
    logic        pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = redirect_pc;
    assign misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    // Low target bits are dropped so the PC always stays word aligned.
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign misaligned      = 1'b0;
`endif

    // ERROR is terminal: redirects there no longer move the PC.
    assign redirect_take = redirect_valid && (state != ERROR);

    // Full blocks a push even if the head leaves in the same cycle, so the
    // push decision only looks at the registered count.
    assign push = (state == FETCH) && (count != FULL) && !redirect_valid;
    assign pop  = (count != '0) && inst_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    state_next = ERROR;
                end else if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (misaligned) begin
                    state_next = ERROR;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, pointers, occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= STARTING_ADDR;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect_take) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            // A misaligned target freezes the PC where it was.
            if (!misaligned) begin
                pc <= redirect_target;
            end
        end else begin
            if (push) begin
                pc   <= pc + 32'd4;
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clock) begin
        if (push) begin
            queue_inst[tail] <= mem_data_out;
            queue_pc[tail]   <= pc;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_error <= 1'b0;
        end else if (redirect_take && misaligned) begin
            fetch_error <= 1'b1;
        end
    end
`else
    assign fetch_error = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_address    = pc;
    assign mem_data_in    = 32'd0;
    assign mem_read_write = 1'b0;
    assign inst_valid     = (count != '0);
    assign inst           = queue_inst[head];
    assign inst_pc        = queue_pc[head];
    assign fsm_state      = state;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter STARTING_ADDR, default 'h01000000, PC value loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 4, instruction-queue entries (power of two, 2..16).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins fetching from current PC.
REQ-006 mem_address  output  32  word address presented to main memory.
REQ-007 mem_data_in  output  32  write data to memory; constant 0.
REQ-008 mem_read_write  output  1  constant 0 (READ); this block never writes.
REQ-009 mem_data_out  input  32  combinational read data for mem_address, same cycle.
REQ-010 inst_valid  output  1  queue head holds an instruction.
REQ-011 inst_ready  input  1  consumer accepts head this cycle.
REQ-012 inst  output  32  head instruction word.
REQ-013 inst_pc  output  32  address the head instruction was fetched from.
REQ-014 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-015 redirect_pc  input  32  new fetch target.
REQ-016 fetch_error  output  1  sticky; set on misaligned redirect (see REQ-034).

Function
REQ-017 FSM states SHALL be IDLE, FETCH, ERROR; reset state IDLE.
REQ-018 IDLE->FETCH on start; redirect in IDLE SHALL load PC and stay IDLE.
REQ-019 FETCH SHALL persist until reset or ERROR entry; start ignored outside IDLE.
REQ-020 mem_address SHALL equal PC every cycle, all states.
REQ-021 Push: in FETCH with count<DEPTH and no redirect, SHALL write {PC, mem_data_out} at tail and PC<=PC+4 at the edge.
REQ-022 count==DEPTH SHALL block push and hold PC, even if a pop occurs that cycle (no fall-through).
REQ-023 Pop: inst_valid && inst_ready SHALL retire head at the edge; inst/inst_pc SHALL update to next entry next cycle.
REQ-024 Push and pop in same cycle SHALL leave count unchanged.
REQ-025 inst_valid SHALL be (count!=0), registered-state derived; inst/inst_pc driven from head entry combinationally.
REQ-026 Latency: first instruction SHALL be valid the cycle after the first FETCH push edge (start edge + 2 edges to valid; push on edge after start).
REQ-027 redirect_valid SHALL take priority over push and pop: queue flushed (count<=0), PC<=redirect_pc, no push that edge.
REQ-028 PC SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 -> 0); head/tail pointers wrap modulo DEPTH.
REQ-029 count SHALL be $clog2(DEPTH)+1 bits, never exceed DEPTH nor underflow.
REQ-030 Pop with count==0 SHALL be ignored.

Reset
REQ-031 reset SHALL asynchronously force: state IDLE, PC=STARTING_ADDR, count/head/tail=0, fetch_error=0.
REQ-032 After reset: inst_valid=0, mem_address=STARTING_ADDR, mem_read_write=0, mem_data_in=0.
REQ-033 Reset mid-fetch SHALL discard queued instructions; fetch resumes only on a new start.

Configuration
REQ-034 With FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 SHALL flush queue, set fetch_error, enter ERROR; ERROR SHALL stop pushes, hold PC, leave only via reset.
REQ-035 Without FETCH_ALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 0, fetch_error tied 0, ERROR unreachable.

Verification
REQ-036 Reset, start, inst_ready=1, memory words 0x00000013,0x00100093,... -> inst_pc 0x01000000,0x01000004,... in order, one per cycle, inst matching memory.
REQ-037 inst_ready=0 after start -> exactly 4 pushes, count=4, mem_address held at 0x01000010; raise inst_ready -> drains in order, fetch resumes.
REQ-038 redirect_pc=0x01000040 with 3 queued -> next-cycle inst_valid=0, then inst_pc=0x01000040; no stale entry observed.
REQ-039 Redirect to 0xFFFFFFF8, inst_ready=1 -> inst_pc sequence 0xFFFFFFF8,0xFFFFFFFC,0x00000000.
REQ-040 Reset asserted asynchronously mid-fetch with 2 queued -> immediately inst_valid=0, mem_address=0x01000000; no fetch until start.
REQ-041 redirect_pc=0x01000042: with FETCH_ALIGN_CHECK_EN -> fetch_error=1, inst_valid=0, PC frozen; without -> fetch proceeds from 0x01000040.
